// File: rtl/rob_commit_reader.sv
// In-order retire side of the ROB: walks a head pointer, moves each occupied head
// entry into a one-deep output register, clears its occupancy, and supports a one-cycle flush.
module rob_commit_reader #(
    parameter int p_depth    = 32,
    parameter int p_ptrwidth = $clog2(p_depth),
    parameter int p_bitwidth = 32,
    parameter int p_cntwidth = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [p_depth-1:0]                  occ,
    input  logic [p_depth-1:0][p_bitwidth-1:0]  data_in,
    output logic [p_depth-1:0]                  clr_occ,
    input  logic                                flush,
    output logic                                deq_val,
    input  logic                                deq_rdy,
    output logic [p_bitwidth-1:0]               deq_msg,
    output logic [p_ptrwidth-1:0]               deq_idx,
    output logic [p_ptrwidth-1:0]               head_ptr,
    output logic [p_cntwidth-1:0]               commit_cnt
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t state, state_nxt;
    logic   load;
    logic   hs;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        hs        = 1'b0;
        clr_occ   = '0;
        case (state)
            RUN: begin
                // only the head entry is ever considered, which keeps retirement strictly in order
                load = occ[head_ptr] & (~deq_val | deq_rdy) & ~flush;
                hs   = deq_val & deq_rdy & ~flush;
                if (load)
                    clr_occ[head_ptr] = 1'b1;
                if (flush)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                clr_occ = '1;
                if (!flush)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            head_ptr   <= '0;
            deq_val    <= 1'b0;
            deq_msg    <= '0;
            deq_idx    <= '0;
            commit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH || flush) begin
                deq_val  <= 1'b0;
                head_ptr <= '0;
            end else if (load) begin
                deq_msg  <= data_in[head_ptr];
                deq_idx  <= head_ptr;
                deq_val  <= 1'b1;
                head_ptr <= (head_ptr == p_ptrwidth'(p_depth - 1)) ? '0
                                                                   : head_ptr + p_ptrwidth'(1);
            end else if (hs) begin
                deq_val <= 1'b0;
            end
            if (hs)
                commit_cnt <= commit_cnt + p_cntwidth'(1);
        end
    end

endmodule

// File: tb/tb_rob_commit_reader.sv
// Self-checking bench for rob_commit_reader: directed scenarios followed by random
// traffic, checked against a queue-based model of the retire stream.
module tb_rob_commit_reader;
    localparam int D = 5;
    localparam int P = $clog2(D);
    localparam int W = 32;
    localparam int C = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [D-1:0]          occ;
    logic [D-1:0][W-1:0]   data_in;
    logic [D-1:0]          clr_occ;
    logic                  flush;
    logic                  deq_val;
    logic                  deq_rdy;
    logic [W-1:0]          deq_msg;
    logic [P-1:0]          deq_idx;
    logic [P-1:0]          head_ptr;
    logic [C-1:0]          commit_cnt;

    rob_commit_reader #(.p_depth(D), .p_ptrwidth(P), .p_bitwidth(W), .p_cntwidth(C)) dut (
        .clk(clk), .rst(rst), .occ(occ), .data_in(data_in), .clr_occ(clr_occ),
        .flush(flush), .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg(deq_msg),
        .deq_idx(deq_idx), .head_ptr(head_ptr), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [W-1:0] msg;
    } ent_t;

    // model: retired-but-unconsumed entries, next index to retire, handshake count
    ent_t         out_q[$];
    int           m_head;
    bit           m_flushing;
    int unsigned  m_cnt;
    logic [D-1:0] pend_clr;
    int           vectors;
    int           miscompares;
    int unsigned  cnt_save;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input int i, input logic [W-1:0] d);
        occ[i]     = 1'b1;
        data_in[i] = d;
    endtask

    task automatic model_reset();
        out_q.delete();
        m_head     = 0;
        m_flushing = 0;
        m_cnt      = 0;
        pend_clr   = '0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic [D-1:0] exp_clr;
        bit           load;
        bit           hs;
        #1;
        load = 0;
        hs   = 0;
        if (m_flushing) begin
            exp_clr = '1;
        end else begin
            load    = occ[m_head] && (out_q.size() == 0 || deq_rdy) && !flush;
            hs      = out_q.size() != 0 && deq_rdy && !flush;
            exp_clr = load ? (D'(1) << m_head) : '0;
        end
        chk("clr_occ", clr_occ, exp_clr);
        if (m_flushing) begin
            m_flushing = flush;
            pend_clr   = '1;
        end else if (flush) begin
            m_flushing = 1;
            out_q.delete();
            m_head = 0;
        end else begin
            if (hs) begin
                void'(out_q.pop_front());
                m_cnt = (m_cnt + 1) % (1 << C);
            end
            if (load) begin
                out_q.push_back('{m_head, data_in[m_head]});
                pend_clr[m_head] = 1'b1;
                m_head = (m_head + 1) % D;
            end
        end
        @(posedge clk);
        #1;
        chk("deq_val", deq_val, out_q.size() != 0);
        if (out_q.size() != 0) begin
            chk("deq_msg", deq_msg, out_q[0].msg);
            chk("deq_idx", deq_idx, out_q[0].idx);
        end
        chk("head_ptr", head_ptr, m_head);
        chk("commit_cnt", commit_cnt, m_cnt);
        @(negedge clk);
        occ      = occ & ~pend_clr;
        pend_clr = '0;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        flush   = 1'b0;
        deq_rdy = 1'b0;
        occ     = '0;
        #1;
        model_reset();
        chk("rst_deq_val", deq_val, 0);
        chk("rst_head", head_ptr, 0);
        chk("rst_cnt", commit_cnt, 0);
        chk("rst_clr_occ", clr_occ, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        data_in     = '0;
        do_reset();

        // single entry, then drain
        write(0, 32'hA5);
        cycle();
        chk("t2_msg", deq_msg, 32'hA5);
        chk("t2_idx", deq_idx, 0);
        chk("t2_head", head_ptr, 1);
        deq_rdy = 1'b1;
        cycle();

        // full stream with wrap back to entry 0
        do_reset();
        for (int i = 0; i < D; i++) write(i, 32'h100 + i);
        deq_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) write(0, 32'h200);
            cycle();
        end
        chk("t3_cnt", commit_cnt, 5);
        chk("t3_idx_wrap", deq_idx, 0);
        chk("t3_head", head_ptr, 1);

        // backpressure holds the output, release loads next entry with no bubble
        deq_rdy = 1'b0;
        write(1, 32'h300);
        for (int c = 0; c < 3; c++) cycle();
        chk("t4_hold", deq_msg, 32'h200);
        deq_rdy = 1'b1;
        cycle();
        chk("t4_next", deq_msg, 32'h300);
        cycle();

        // strict in-order: later occupied entry waits for the head
        do_reset();
        deq_rdy = 1'b1;
        write(2, 32'h22);
        for (int c = 0; c < 10; c++) cycle();
        chk("t5_head_wait", head_ptr, 0);
        write(0, 32'h20);
        cycle();
        chk("t5_first", deq_idx, 0);
        write(1, 32'h21);
        for (int c = 0; c < 3; c++) cycle();

        // flush with a held output and several occupied entries
        deq_rdy = 1'b0;
        write(3, 32'h33); write(4, 32'h44); write(0, 32'h40); write(1, 32'h41);
        cycle();
        cnt_save = m_cnt;
        flush = 1'b1;
        cycle();
        chk("t6_deq_val", deq_val, 0);
        flush = 1'b0;
        cycle();
        chk("t6_head", head_ptr, 0);
        chk("t6_cnt", commit_cnt, cnt_save);
        chk("t6_occ_clr", occ, 0);

        // random traffic
        for (int c = 0; c < 700; c++) begin
            flush   = ($urandom % 40) == 0;
            deq_rdy = ($urandom % 4) != 0;
            if (!m_flushing && !flush && ($urandom % 3) != 0) begin
                int i;
                i = $urandom_range(D - 1);
                if (!occ[i]) write(i, $urandom);
            end
            cycle();
        end

        // asynchronous reset mid-stream
        flush = 1'b0;
        for (int i = 0; i < D; i++) if (!occ[i]) write(i, $urandom);
        deq_rdy = 1'b1;
        cycle();
        #2;
        do_reset();
        for (int c = 0; c < 50; c++) begin
            deq_rdy = ($urandom % 2) != 0;
            if (($urandom % 2) != 0) begin
                int i;
                i = $urandom_range(D - 1);
                if (!occ[i]) write(i, $urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end
endmodule
